// File: rtl/mult_seq_nxn.sv
// Sequential shift-add multiplier, one multiplier bit per clock, valid/ready I/O.
// Define MULT_SIGNED_EN to add the is_signed port (two's-complement operands).
module mult_seq_nxn #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef MULT_SIGNED_EN
  input  logic               is_signed,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t               state;
  state_t               state_nx;
  logic [2*WIDTH-1:0]   a_reg;
  logic [2*WIDTH-1:0]   a_ext;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_nx;
  logic [2*WIDTH-1:0]   term;
  logic [WIDTH-1:0]     b_reg;
  logic [CW-1:0]        count;
  logic                 sgn;
  logic                 sgn_in;
  logic                 last;

`ifdef MULT_SIGNED_EN
  assign sgn_in = is_signed;
`else
  assign sgn_in = 1'b0;
`endif

  assign a_ext     = {{WIDTH{sgn_in & a[WIDTH-1]}}, a};
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // The multiplier's sign bit carries weight -2^(W-1), hence the final subtract.
  always_comb begin
    last   = (count == LAST);
    term   = b_reg[count] ? (a_reg << count) : '0;
    acc_nx = (sgn && last) ? (acc - term) : (acc + term);
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (in_valid) state_nx = RUN;
      RUN:  if (last) state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_reg <= '0;
      b_reg <= '0;
      sgn   <= 1'b0;
      acc   <= '0;
      count <= '0;
      p     <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a_ext;
            b_reg <= b;
            sgn   <= sgn_in;
            acc   <= '0;
            count <= '0;
          end
        end
        RUN: begin
          acc   <= acc_nx;
          count <= count + CW'(1);
          if (last) p <= acc_nx;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_nxn.sv
// Randomized self-checking bench for mult_seq_nxn against an arithmetic model.
// Signed cases are exercised when MULT_SIGNED_EN is defined.
module tb_mult_seq_nxn;

  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
`ifdef MULT_SIGNED_EN
  logic           is_signed;
`endif
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] p;

  int checks;
  int passed;

  mult_seq_nxn #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
`ifdef MULT_SIGNED_EN
    .is_signed (is_signed),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] mul_ref(
    input logic [W-1:0] x, input logic [W-1:0] y, input bit s);
    logic [2*W-1:0] ex;
    logic [2*W-1:0] ey;
    ex = {{W{s & x[W-1]}}, x};
    ey = {{W{s & y[W-1]}}, y};
    return ex * ey;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(
    input  logic [W-1:0]   xa,
    input  logic [W-1:0]   xb,
    input  bit             s,
    input  int             hold,
    input  bit             scramble,
    output logic [2*W-1:0] got,
    output int             lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 100) begin
      step();
      guard++;
    end
    a = xa;
    b = xb;
`ifdef MULT_SIGNED_EN
    is_signed = s;
`else
    if (s) $display("note: signed op requested without MULT_SIGNED_EN");
`endif
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      if (scramble) begin
        a = W'($urandom);
        b = W'($urandom);
`ifdef MULT_SIGNED_EN
        is_signed = 1'($urandom);
`endif
      end
      step();
      lat++;
    end
    got = p;
    repeat (hold) step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if (in_ready !== 1'b1)
      $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    else passed++;
    checks++;
    if (out_valid !== 1'b0)
      $display("FAIL reset_out_valid got=%b exp=0", out_valid);
    else passed++;
    checks++;
    if (p !== '0)
      $display("FAIL reset_p got=%h exp=0", p);
    else passed++;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_corners();
    logic [W-1:0]   ta [3];
    logic [W-1:0]   tb [3];
    logic [2*W-1:0] got;
    logic [2*W-1:0] exp;
    int             lat;
    ta = '{8'h00, 8'hFF, 8'h0F};
    tb = '{8'hFF, 8'hFF, 8'h0F};
    for (int i = 0; i < 3; i++) begin
      exp = mul_ref(ta[i], tb[i], 1'b0);
      do_op(ta[i], tb[i], 1'b0, 0, 1'b0, got, lat);
      checks++;
      if (got !== exp)
        $display("FAIL corner_p%0d got=%h exp=%h", i, got, exp);
      else passed++;
      checks++;
      if (lat !== W)
        $display("FAIL corner_lat%0d got=%0d exp=%0d", i, lat, W);
      else passed++;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0)
        $display("FAIL corner_idle%0d got=%b%b exp=10",
                 i, in_ready, out_valid);
      else passed++;
    end
  endtask

  task automatic test_stall();
    int guard;
    a = 8'd13;
    b = 8'd11;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0)
      $display("FAIL stall_busy got=%b exp=0", in_ready);
    else passed++;
    guard = 0;
    while (!out_valid && guard < 100) begin
      step();
      guard++;
    end
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'($urandom);
      a = W'($urandom);
      b = W'($urandom);
      step();
      checks++;
      if (out_valid !== 1'b1 || p !== 16'd143 || in_ready !== 1'b0)
        $display("FAIL stall_hold%0d got=%b/%h/%b exp=1/008f/0",
                 i, out_valid, p, in_ready);
      else passed++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || p !== 16'd143)
      $display("FAIL stall_release got=%b/%b/%h exp=1/0/008f",
               in_ready, out_valid, p);
    else passed++;
  endtask

  task automatic test_scramble();
    logic [2*W-1:0] got;
    int             lat;
    do_op(8'd7, 8'd9, 1'b0, 1, 1'b1, got, lat);
    checks++;
    if (got !== 16'd63)
      $display("FAIL scramble_p got=%0d exp=63", got);
    else passed++;
  endtask

  task automatic test_mid_reset();
    logic [2*W-1:0] got;
    int             lat;
    a = 8'd200;
    b = 8'd100;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || p !== '0 || in_ready !== 1'b1)
      $display("FAIL midrst_outputs got=%b/%h/%b exp=0/0000/1",
               out_valid, p, in_ready);
    else passed++;
    step();
    rst_n = 1'b1;
    step();
    do_op(8'd2, 8'd3, 1'b0, 0, 1'b0, got, lat);
    checks++;
    if (got !== 16'd6 || lat !== W)
      $display("FAIL midrst_next got=%0d/%0d exp=6/%0d", got, lat, W);
    else passed++;
  endtask

`ifdef MULT_SIGNED_EN
  task automatic test_signed();
    logic [W-1:0]   ta [3];
    logic [W-1:0]   tb [3];
    bit             ts [3];
    logic [2*W-1:0] ex [3];
    logic [2*W-1:0] got;
    int             lat;
    ta = '{8'hFD, 8'h80, 8'hFD};
    tb = '{8'h05, 8'h80, 8'h05};
    ts = '{1'b1, 1'b1, 1'b0};
    ex = '{16'hFFF1, 16'h4000, 16'd1265};
    for (int i = 0; i < 3; i++) begin
      do_op(ta[i], tb[i], ts[i], 0, 1'b0, got, lat);
      checks++;
      if (got !== ex[i] || lat !== W)
        $display("FAIL signed%0d got=%h/%0d exp=%h/%0d",
                 i, got, lat, ex[i], W);
      else passed++;
    end
  endtask
`endif

  task automatic test_random();
    logic [W-1:0]   xa;
    logic [W-1:0]   xb;
    bit             s;
    logic [2*W-1:0] got;
    logic [2*W-1:0] exp;
    int             lat;
    for (int i = 0; i < 40; i++) begin
      xa = W'($urandom);
      xb = W'($urandom);
`ifdef MULT_SIGNED_EN
      s = 1'($urandom);
`else
      s = 1'b0;
`endif
      exp = mul_ref(xa, xb, s);
      do_op(xa, xb, s, int'($urandom_range(0, 2)),
            1'($urandom), got, lat);
      checks++;
      if (got !== exp || lat !== W)
        $display("FAIL random%0d a=%h b=%h s=%0d got=%h/%0d exp=%h/%0d",
                 i, xa, xb, s, got, lat, exp, W);
      else passed++;
    end
  endtask

  initial begin
    checks    = 0;
    passed    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
`ifdef MULT_SIGNED_EN
    is_signed = 1'b0;
`endif
    test_reset();
    test_corners();
    test_stall();
    test_scramble();
    test_mid_reset();
`ifdef MULT_SIGNED_EN
    test_signed();
`endif
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
